// File: rtl/mfp_seven_segment_scanner.sv
// mfp_seven_segment_scanner: time-multiplexed seven-segment driver with guard gaps between digits.
// Optional decimal-point support is enabled by defining MFP_SEVEN_SEG_DP_EN.
module mfp_seven_segment_scanner #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DEPTH = 16,
    parameter int GUARD      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   number,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seven_segments,
    output logic                  dot,
    output logic [DIGITS-1:0]     anodes
);
    localparam int IW = $clog2(DIGITS);

    typedef enum logic {S_GUARD, S_SHOW} state_t;

    state_t                state;
    logic [7:0]            guard_cnt;
    logic [SCAN_DEPTH-1:0] dwell_cnt;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         nxt;
    logic [3:0]            nib;
    logic                  en;
    logic                  enter;
    logic                  leave;

    // Active-low hex font, bit order g..a.
    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0:    decode = 7'b1000000;
            4'h1:    decode = 7'b1111001;
            4'h2:    decode = 7'b0100100;
            4'h3:    decode = 7'b0110000;
            4'h4:    decode = 7'b0011001;
            4'h5:    decode = 7'b0010010;
            4'h6:    decode = 7'b0000010;
            4'h7:    decode = 7'b1111000;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0010000;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b0000011;
            4'hC:    decode = 7'b1000110;
            4'hD:    decode = 7'b0100001;
            4'hE:    decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // Next slot index (wraps at DIGITS-1, so non-power-of-two counts never skip) and its inputs.
    always_comb begin
        nxt   = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        nib   = number[4*nxt +: 4];
        en    = digit_en[nxt];
        enter = (state == S_GUARD) && (guard_cnt == 8'(GUARD - 1));
        leave = (state == S_SHOW) && (&dwell_cnt);
    end

    // Scan FSM; anodes and segments are loaded together on the SHOW entry edge, which also
    // serves as the anti-tearing snapshot of the selected digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_GUARD;
            guard_cnt      <= '0;
            dwell_cnt      <= '0;
            idx            <= IW'(DIGITS - 1);
            anodes         <= '1;
            seven_segments <= 7'h7F;
        end else if (state == S_GUARD) begin
            guard_cnt <= enter ? 8'd0 : guard_cnt + 1'b1;
            if (enter) begin
                state          <= S_SHOW;
                idx            <= nxt;
                dwell_cnt      <= '0;
                anodes         <= en ? ~(DIGITS'(1) << nxt) : '1;
                seven_segments <= en ? decode(nib) : 7'h7F;
            end
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
            if (leave) begin
                state          <= S_GUARD;
                anodes         <= '1;
                seven_segments <= 7'h7F;
            end
        end
    end

`ifdef MFP_SEVEN_SEG_DP_EN
    logic dp_sel;

    assign dp_sel = dp_in[nxt] & en;

    // Decimal point follows the same entry/exit edges as the anodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dot <= 1'b1;
        else
            dot <= enter ? ~dp_sel : (leave ? 1'b1 : dot);
    end
`else
    logic unused_dp;

    assign unused_dp = ^dp_in;
    assign dot       = 1'b1;
`endif

endmodule

// File: tb/tb_mfp_seven_segment_scanner.sv
// tb_mfp_seven_segment_scanner: scoreboard bench for the seven-segment scanner (4 digits, short dwell).
module tb_mfp_seven_segment_scanner;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] number;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [6:0]  seven_segments;
    logic        dot;
    logic [3:0]  anodes;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   sample = 0;

`ifdef MFP_SEVEN_SEG_DP_EN
    localparam logic D2 = 1'b0;
`else
    localparam logic D2 = 1'b1;
`endif

    mfp_seven_segment_scanner #(.DIGITS(4), .SCAN_DEPTH(3), .GUARD(2)) dut (
        .clk(clk),
        .rst(rst),
        .number(number),
        .digit_en(digit_en),
        .dp_in(dp_in),
        .seven_segments(seven_segments),
        .dot(dot),
        .anodes(anodes)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if ({anodes, seven_segments, dot} !== {e.an, e.seg, e.dt}) begin
                fails++;
                $display("FAIL scan sample=%0d got an=%b seg=%b dot=%b exp an=%b seg=%b dot=%b",
                         sample, anodes, seven_segments, dot, e.an, e.seg, e.dt);
            end
            tests++;
            if ($countones(~anodes) > 1) begin
                fails++;
                $display("FAIL onehot sample=%0d got an=%b exp at most one low", sample, anodes);
            end
            sample++;
        end
    end

    task automatic push(input logic [3:0] an, input logic [6:0] seg, input logic dt, input int n);
        exp_t e;
        e = '{an: an, seg: seg, dt: dt};
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    task automatic slot(input logic [3:0] an, input logic [6:0] seg, input logic dt);
        push(4'hF, 7'h7F, 1'b1, 2);
        push(an, seg, dt, 8);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        number   = 16'h3210;
        digit_en = 4'hF;
        dp_in    = 4'b0100;
        @(posedge clk);
        #1;
        push(4'hF, 7'h7F, 1'b1, 3);
        run(3);
        rst = 1'b0;
        // Lap 1: all digits, full 40-cycle period.
        slot(4'b1110, 7'b1000000, 1'b1);
        slot(4'b1101, 7'b1111001, 1'b1);
        slot(4'b1011, 7'b0100100, D2);
        slot(4'b0111, 7'b0110000, 1'b1);
        run(40);
        // Lap 2: digit 2 disabled, timing unchanged.
        digit_en = 4'b1011;
        slot(4'b1110, 7'b1000000, 1'b1);
        slot(4'b1101, 7'b1111001, 1'b1);
        slot(4'b1111, 7'h7F, 1'b1);
        slot(4'b0111, 7'b0110000, 1'b1);
        run(40);
        // Lap 3: number changes mid-SHOW of digit 1.
        digit_en = 4'hF;
        slot(4'b1110, 7'b1000000, 1'b1);
        slot(4'b1101, 7'b1111001, 1'b1);
        slot(4'b1011, 7'b0001110, D2);
        slot(4'b0111, 7'b0001110, 1'b1);
        run(15);
        number = 16'hFFFF;
        run(25);
        // Lap 4: asynchronous reset mid-SHOW of digit 0.
        number = 16'h3210;
        push(4'hF, 7'h7F, 1'b1, 2);
        push(4'b1110, 7'b1000000, 1'b1, 3);
        run(5);
        rst = 1'b1;
        push(4'hF, 7'h7F, 1'b1, 1);
        run(1);
        rst = 1'b0;
        slot(4'b1110, 7'b1000000, 1'b1);
        slot(4'b1101, 7'b1111001, 1'b1);
        run(20);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
